sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; next-generation replacement for the team's fixed 8x8 FIFO.
- Generalised in data width and depth.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a read-valid strobe, and a first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer datapaths in the same clock domain.

---
 rtl/sync_fifo_param.sv | 141 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// a read-valid strobe and an optional first-word-fall-through read mode.
module sync_fifo_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AF_TH  = DEPTH - 2,
    parameter int unsigned AE_TH  = 2,
    parameter int unsigned FWFT   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   fifo_words,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] head;

    // Status flags are pure functions of the registered occupancy.
    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
        fifo_words   = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Accept handshakes against the pre-edge full/empty state.
    always_comb begin
        wr_acc = wr_en & ~full;
        rd_acc = rd_en & ~empty;
        head   = mem_q[rd_ptr_q];
    end

    // Read port: fall-through shows the head word directly, zeroed while empty
    // so the reset value of data_out matches standard mode.
    always_comb begin
        if (FWFT != 0) begin
            data_out = empty ? '0 : head;
            rd_valid = ~empty;
        end else begin
            data_out = data_out_q;
            rd_valid = rd_valid_q;
        end
    end

    // Next-state for pointers, occupancy, registered read data and error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            data_out_d = head;
            rd_valid_d = 1'b1;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A new error in the same cycle as clr_err takes priority.
        if (wr_en & full) begin
            overflow_d = 1'b1;
        end
        if (rd_en & empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives a standard-mode and a fall-through instance with
// identical stimulus and checks both against a queue-based reference model.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic       s_full, s_af, s_empty, s_ae, s_rv, s_ovf, s_udf;
    logic [7:0] s_dout;
    logic [4:0] s_fw;
    logic       f_full, f_af, f_empty, f_ae, f_rv, f_ovf, f_udf;
    logic [7:0] f_dout;
    logic [4:0] f_fw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_TH(14), .AE_TH(2), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .full(s_full), .almost_full(s_af), .rd_en(rd_en), .data_out(s_dout),
        .rd_valid(s_rv), .empty(s_empty), .almost_empty(s_ae), .fifo_words(s_fw),
        .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_TH(14), .AE_TH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
        .full(f_full), .almost_full(f_af), .rd_en(rd_en), .data_out(f_dout),
        .rd_valid(f_rv), .empty(f_empty), .almost_empty(f_ae), .fifo_words(f_fw),
        .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the observable registers.
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic       m_rv = 1'b0;
    logic [7:0] m_dout = 8'h00;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_udf  = 1'b0;
                m_rv   = 1'b0;
                m_dout = 8'h00;
            end else begin
                bit was_full;
                bit was_empty;
                was_full  = (mq.size() == 16);
                was_empty = (mq.size() == 0);
                m_ovf = (clr_err ? 1'b0 : m_ovf) | (wr_en & was_full);
                m_udf = (clr_err ? 1'b0 : m_udf) | (rd_en & was_empty);
                m_rv  = 1'b0;
                if (rd_en && !was_empty) begin
                    m_dout = mq.pop_front();
                    m_rv   = 1'b1;
                end
                if (wr_en && !was_full) begin
                    mq.push_back(data_in);
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("s_fifo_words", 32'(s_fw), n);
        chk("f_fifo_words", 32'(f_fw), n);
        chk("s_full", 32'(s_full), 32'(n == 16));
        chk("f_full", 32'(f_full), 32'(n == 16));
        chk("s_empty", 32'(s_empty), 32'(n == 0));
        chk("f_empty", 32'(f_empty), 32'(n == 0));
        chk("s_almost_full", 32'(s_af), 32'(n >= 14));
        chk("f_almost_full", 32'(f_af), 32'(n >= 14));
        chk("s_almost_empty", 32'(s_ae), 32'(n <= 2));
        chk("f_almost_empty", 32'(f_ae), 32'(n <= 2));
        chk("s_overflow", 32'(s_ovf), 32'(m_ovf));
        chk("f_overflow", 32'(f_ovf), 32'(m_ovf));
        chk("s_underflow", 32'(s_udf), 32'(m_udf));
        chk("f_underflow", 32'(f_udf), 32'(m_udf));
        chk("s_rd_valid", 32'(s_rv), 32'(m_rv));
        chk("s_data_out", 32'(s_dout), 32'(m_dout));
        chk("f_rd_valid", 32'(f_rv), 32'(n != 0));
        if (n != 0) begin
            chk("f_data_out", 32'(f_dout), 32'(mq[0]));
        end
    end

    // One clock of stimulus; returns just after the edge that consumed it.
    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fifo_words", 32'(s_fw), 0);
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_almost_empty", 32'(s_ae), 1);
        chk("rst_full", 32'(s_full), 0);
        chk("rst_almost_full", 32'(s_af), 0);
        chk("rst_data_out", 32'(s_dout), 0);
        chk("rst_rd_valid", 32'(s_rv), 0);
        chk("rst_f_rd_valid", 32'(f_rv), 0);
        chk("rst_overflow", 32'(s_ovf), 0);
        chk("rst_underflow", 32'(s_udf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 13) chk("af_at_13", 32'(s_af), 0);
            if (i == 14) chk("af_at_14", 32'(s_af), 1);
            if (i == 15) chk("full_at_15", 32'(s_full), 0);
        end
        chk("full_at_16", 32'(s_full), 1);
        chk("words_at_16", 32'(s_fw), 16);
        chk("fwft_head_full", 32'(f_dout), 32'h01);

        // Overflow and clear
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("overflow_set", 32'(s_ovf), 1);
        chk("words_after_ovf", 32'(s_fw), 16);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("overflow_clr", 32'(s_ovf), 0);

        // Drain in order; 0xAA must not appear
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_rd_valid", 32'(s_rv), 1);
            chk("drain_data", 32'(s_dout), 32'(i + 1));
        end
        chk("drain_empty", 32'(s_empty), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_rd_valid", 32'(s_rv), 0);
        chk("idle_data_hold", 32'(s_dout), 32'h10);

        // Underflow
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("underflow_set", 32'(s_udf), 1);
        chk("underflow_rd_valid", 32'(s_rv), 0);
        chk("underflow_data_hold", 32'(s_dout), 32'h10);
        chk("underflow_words", 32'(s_fw), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("underflow_clr", 32'(s_udf), 0);

        // Offset pointers to 8 so the streaming phase wraps
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("offset_data", 32'(s_dout), 32'(8'h40 + i));
        end

        // Steady-state stream at 5 words, wrapping both pointers
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
            chk("stream_words", 32'(s_fw), 5);
            chk("stream_data", 32'(s_dout), (i < 5) ? 32'(8'h30 + i) : 32'(8'h20 + i - 5));
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("stream_tail", 32'(s_dout), 32'(8'h25 + i));
        end
        chk("stream_empty", 32'(s_empty), 1);

        // Fall-through visibility
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_rd_valid", 32'(f_rv), 1);
        chk("fwft_data", 32'(f_dout), 32'h5A);
        chk("std_no_rd_valid", 32'(s_rv), 0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_consumed_rv", 32'(f_rv), 0);
        chk("fwft_consumed_empty", 32'(f_empty), 1);
        chk("std_5a_rv", 32'(s_rv), 1);
        chk("std_5a_data", 32'(s_dout), 32'h5A);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        wr_en = 1'b0;
        chk("pre_reset_words", 32'(s_fw), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_words", 32'(s_fw), 0);
        chk("async_rst_empty", 32'(s_empty), 1);
        chk("async_rst_data", 32'(s_dout), 0);
        chk("async_rst_f_rv", 32'(f_rv), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_reset_data", 32'(s_dout), 32'h77);
        chk("post_reset_words", 32'(s_fw), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
